captura_pin: RTL

- Keypad front-end placed directly upstream of the parking-gate controller.
- Collects decimal key presses into an 8-bit PIN (two BCD digits).
- On the enter key, drives `Pin` and a qualifying strobe for a fixed window. Otherwise `Pin` holds the idle code the controller expects.
- Handles backspace, clear and an inactivity timeout.

---
 rtl/pin_pkg.sv | 35 +++
 rtl/contador_inactividad.sv | 30 +++
 rtl/captura_pin.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pin_pkg.sv
// Shared definitions for the keypad PIN front-end and its neighbours:
// key codes, state encoding and the idle code driven on the PIN bus.
package pin_pkg;

  // Control key codes on Tecla
  localparam logic [3:0] TECLA_BORRAR  = 4'hA;
  localparam logic [3:0] TECLA_LIMPIAR = 4'hB;
  localparam logic [3:0] TECLA_ENTER   = 4'hE;

  // Idle code the gate controller expects when no PIN is being delivered
  localparam logic [7:0] PIN_ESPERA = 8'h00;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    CAPTURA  = 2'd1,
    COMPLETO = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

  // Decimal digit keys are 0..9
  function automatic logic es_digito(input logic [3:0] tecla);
    return (tecla <= 4'd9);
  endfunction

  // Capture state implied by a buffered digit count
  function automatic estado_t estado_por_cuenta(input int cuenta, input int n_digitos);
    if (cuenta <= 0)
      return ESPERA;
    else if (cuenta >= n_digitos)
      return COMPLETO;
    else
      return CAPTURA;
  endfunction

endpackage

// File: rtl/contador_inactividad.sv
// Idle-cycle counter. Counts while enabled, saturates at TIMEOUT and
// flags expiry on the cycle whose edge makes the count reach TIMEOUT.
module contador_inactividad #(
  parameter int TIMEOUT = 50
) (
  input  logic Clk,
  input  logic Reset,
  input  logic habilitar,
  input  logic limpiar,
  output logic expirado
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cuenta_reg;

  // Count enabled idle cycles; clear has priority, hold once TIMEOUT is reached
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      cuenta_reg <= '0;
    else if (limpiar)
      cuenta_reg <= '0;
    else if (habilitar && (cuenta_reg != CW'(TIMEOUT)))
      cuenta_reg <= cuenta_reg + 1'b1;
  end

  // Expiry is seen one cycle early so the owner acts on the reaching edge
  assign expirado = habilitar && (cuenta_reg >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/captura_pin.sv
// Keypad front-end: assembles BCD digits into a PIN, delivers it with a
// qualifying strobe on enter, handles backspace, clear and idle timeout.
module captura_pin
  import pin_pkg::*;
#(
  parameter int                       N_DIGITOS  = 2,
  parameter int                       TIMEOUT    = 50,
  parameter int                       T_PULSO    = 1,
  parameter logic [4*N_DIGITOS-1:0]   PIN_ESPERA = pin_pkg::PIN_ESPERA
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [3:0]                     Tecla,
  input  logic                           Tecla_valida,
  output logic [4*N_DIGITOS-1:0]         Pin,
  output logic                           Pin_listo,
  output logic [$clog2(N_DIGITOS+1)-1:0] Digitos,
  output logic                           Error_entrada
);

  localparam int W  = 4 * N_DIGITOS;
  localparam int CW = $clog2(N_DIGITOS + 1);
  localparam int PW = (T_PULSO > 1) ? $clog2(T_PULSO) : 1;

  estado_t         estado_reg, estado_next;
  logic [W-1:0]    buffer_reg, buffer_next;
  logic [CW-1:0]   digitos_reg, digitos_next;
  logic [W-1:0]    pin_reg, pin_next;
  logic            listo_reg, listo_next;
  logic            error_reg, error_next;
  logic [PW-1:0]   pulso_reg, pulso_next;

  logic [W-1:0]    buffer_ins;
  logic [W-1:0]    buffer_del;
  logic            es_dig, es_borrar, es_limpiar, es_enter;
  logic            acepta;
  logic            expirado;
  logic            habilitar_cnt, limpiar_cnt;

  // Per-digit lanes: shift a new digit in at the bottom, or drop the last one
  genvar gi;
  for (gi = 0; gi < N_DIGITOS; gi++) begin : g_digito
    if (gi == 0) begin : g_lsd
      assign buffer_ins[3:0] = Tecla;
    end else begin : g_ins
      assign buffer_ins[gi*4 +: 4] = buffer_reg[(gi-1)*4 +: 4];
    end
    if (gi == N_DIGITOS - 1) begin : g_msd
      assign buffer_del[gi*4 +: 4] = 4'h0;
    end else begin : g_del
      assign buffer_del[gi*4 +: 4] = buffer_reg[(gi+1)*4 +: 4];
    end
  end

  assign es_dig     = es_digito(Tecla);
  assign es_borrar  = (Tecla == TECLA_BORRAR);
  assign es_limpiar = (Tecla == TECLA_LIMPIAR);
  assign es_enter   = (Tecla == TECLA_ENTER);

  // A key is accepted only when it has an effect; reserved codes never are
  assign acepta = Tecla_valida && (estado_reg != ENTREGA) &&
                  ((es_dig && (estado_reg != COMPLETO)) ||
                   (es_borrar && (estado_reg != ESPERA)) ||
                   es_limpiar || es_enter);

  assign habilitar_cnt = (estado_reg == CAPTURA) || (estado_reg == COMPLETO);
  assign limpiar_cnt   = acepta || (estado_next == ESPERA) || (estado_next == ENTREGA);

  contador_inactividad #(
    .TIMEOUT (TIMEOUT)
  ) u_inactividad (
    .Clk       (Clk),
    .Reset     (Reset),
    .habilitar (habilitar_cnt),
    .limpiar   (limpiar_cnt),
    .expirado  (expirado)
  );

  // Next-state and next-output decode; an accepted key beats a timeout
  always_comb begin
    estado_next  = estado_reg;
    buffer_next  = buffer_reg;
    digitos_next = digitos_reg;
    pin_next     = pin_reg;
    listo_next   = listo_reg;
    error_next   = 1'b0;
    pulso_next   = pulso_reg;

    if (estado_reg == ENTREGA) begin
      if (pulso_reg == '0) begin
        estado_next = ESPERA;
        pin_next    = PIN_ESPERA;
        listo_next  = 1'b0;
      end else begin
        pulso_next = pulso_reg - 1'b1;
      end
    end else if (acepta) begin
      if (es_dig) begin
        buffer_next  = buffer_ins;
        digitos_next = digitos_reg + 1'b1;
        estado_next  = estado_por_cuenta(int'(digitos_reg) + 1, N_DIGITOS);
      end else if (es_borrar) begin
        buffer_next  = buffer_del;
        digitos_next = digitos_reg - 1'b1;
        estado_next  = estado_por_cuenta(int'(digitos_reg) - 1, N_DIGITOS);
      end else if (es_limpiar) begin
        buffer_next  = '0;
        digitos_next = '0;
        estado_next  = ESPERA;
      end else begin
        buffer_next  = '0;
        digitos_next = '0;
        if (estado_reg == COMPLETO) begin
          estado_next = ENTREGA;
          pin_next    = buffer_reg;
          listo_next  = 1'b1;
          pulso_next  = PW'(T_PULSO - 1);
        end else begin
          estado_next = ESPERA;
          error_next  = 1'b1;
        end
      end
    end else if (expirado) begin
      buffer_next  = '0;
      digitos_next = '0;
      estado_next  = ESPERA;
      error_next   = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      estado_reg  <= ESPERA;
      buffer_reg  <= '0;
      digitos_reg <= '0;
      pin_reg     <= PIN_ESPERA;
      listo_reg   <= 1'b0;
      error_reg   <= 1'b0;
      pulso_reg   <= '0;
    end else begin
      estado_reg  <= estado_next;
      buffer_reg  <= buffer_next;
      digitos_reg <= digitos_next;
      pin_reg     <= pin_next;
      listo_reg   <= listo_next;
      error_reg   <= error_next;
      pulso_reg   <= pulso_next;
    end
  end

  assign Pin           = pin_reg;
  assign Pin_listo     = listo_reg;
  assign Digitos       = digitos_reg;
  assign Error_entrada = error_reg;

endmodule
